// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared constants and state type for the SM3 message feeder
//
// Purpose: command encodings, status bit position, block geometry and the
//          feeder state enum used by sm3_msg_feeder and sm3_pad_buf.
// Ports:   none (package).

package sm3_pkg;

  // Core command encodings on core_cmd_i, laid out as {cont,start,read}.
  localparam logic [2:0] CMD_START = 3'b010;
  localparam logic [2:0] CMD_CONT  = 3'b110;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Position of the busy flag in the core status word.
  localparam int BUSY_BIT = 3;

  // One SM3 block is 64 bytes; the 64-bit length field starts at byte 56.
  localparam int BLK_BYTES = 64;
  localparam int LEN_OFS   = 56;

  typedef enum logic [2:0] {
    S_FILL,
    S_PAD,
    S_START,
    S_SEND,
    S_WAIT,
    S_RDCMD,
    S_READ,
    S_OUT
  } feeder_state_e;

endpackage

// File: rtl/sm3_pad_buf.sv
// rtl/sm3_pad_buf.sv - 64-byte block buffer with byte write and word read
//
// Purpose: holds one 512-bit SM3 block while it is filled byte by byte and
//          then streamed out as 16 big-endian 32-bit words.
// Ports:
//   clk      in   1   clock
//   clear    in   1   synchronous clear of all bytes to zero
//   wr_en    in   1   byte write enable
//   wr_ptr   in   6   byte address 0..63
//   wr_data  in   8   byte to write
//   rd_idx   in   4   word index 0..15
//   rd_word  out  32  word rd_idx, byte 4*rd_idx in bits 31:24

module sm3_pad_buf
  import sm3_pkg::*;
(
  input  logic        clk,
  input  logic        clear,
  input  logic        wr_en,
  input  logic [5:0]  wr_ptr,
  input  logic [7:0]  wr_data,
  input  logic [3:0]  rd_idx,
  output logic [31:0] rd_word
);

  logic [7:0] mem [BLK_BYTES];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < BLK_BYTES; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_word = {mem[{rd_idx, 2'd0}], mem[{rd_idx, 2'd1}],
                    mem[{rd_idx, 2'd2}], mem[{rd_idx, 2'd3}]};

endmodule

// File: rtl/sm3_msg_feeder.sv
// rtl/sm3_msg_feeder.sv - byte-stream initiator for the SM3 core cmd/din/dout interface
//
// Purpose: accepts message bytes, applies SM3 padding (0x80, zero fill,
//          64-bit big-endian bit length), issues start/continue commands,
//          streams each block as 16 words, then reads back the 256-bit digest.
// Build option: SM3_FEEDER_ZEROIZE_EN - clear buffer and digest after the
//          digest handshake and drive core_din to zero outside word streaming.
// Ports:
//   clk           in   1    clock
//   reset         in   1    synchronous, active-high
//   in_data       in   8    message byte (first byte of a word -> bits 31:24)
//   in_valid      in   1    byte valid
//   in_last       in   1    final byte of the message
//   in_ready      out  1    byte accepted when in_valid & in_ready
//   digest        out  256  {A..H}, A in 255:224
//   digest_valid  out  1    held until digest_ready
//   digest_ready  in   1    consumer accept
//   core_din      out  32   block word to core
//   core_dout     in   32   digest word from core
//   core_cmd_i    out  3    command {cont,start,read}
//   core_cmd_w    out  1    single-cycle command write strobe
//   core_cmd_o    in   4    core status, bit 3 = busy

module sm3_msg_feeder
  import sm3_pkg::*;
#(
  parameter int LEN_W    = 64,
  parameter int READ_LAT = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [255:0] digest,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [31:0]  core_din,
  input  logic [31:0]  core_dout,
  output logic [2:0]   core_cmd_i,
  output logic         core_cmd_w,
  input  logic [3:0]   core_cmd_o
);

`ifdef SM3_FEEDER_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  // Read counter must reach READ_LAT-1+7 (last digest word).
  localparam int RD_W = $clog2(READ_LAT + 8) + 1;

  feeder_state_e state, state_d;

  logic [5:0]       ptr;
  logic [LEN_W-1:0] bitlen;
  logic             need80;       // 0x80 terminator still to be written
  logic             no_len;       // 0x80 landed in 56..63, length goes in the next block
  logic             final_blk;    // block being processed carries the length
  logic             pad_pending;  // another pad-only block follows this one
  logic             first_blk;    // next START is the first block of a message
  logic [3:0]       word_idx;
  logic [RD_W-1:0]  rd_cnt;

  logic             buf_we;
  logic [7:0]       buf_wdata;
  logic             buf_clear;
  logic [3:0]       buf_rd_idx;
  logic [31:0]      buf_word;

  logic [63:0]      len64;
  logic             at_end;
  logic             in_len_field;
  logic             block_has_len;
  logic             busy;
  logic             rd_capture;
  logic [2:0]       rd_word_idx;
  logic             unused_status;

  assign len64         = 64'(bitlen);
  assign at_end        = (ptr == 6'(BLK_BYTES - 1));
  assign in_len_field  = !no_len && (ptr >= 6'(LEN_OFS));
  // Whether the block closing now holds the length; a 0x80 written at
  // byte 56 or later pushes the length into an extra block.
  assign block_has_len = need80 ? (ptr < 6'(LEN_OFS)) : !no_len;
  assign busy          = core_cmd_o[BUSY_BIT];
  assign unused_status = ^core_cmd_o[2:0];
  assign rd_capture    = (rd_cnt >= RD_W'(READ_LAT - 1));
  assign rd_word_idx   = 3'(rd_cnt - RD_W'(READ_LAT - 1));

  // Word 0 is fetched during START so it is on core_din in the first SEND cycle.
  assign buf_rd_idx = (state == S_SEND) ? (word_idx + 4'd1) : 4'd0;
  assign buf_clear  = reset || (ZEROIZE && (state == S_OUT) && digest_ready);

  sm3_pad_buf u_buf (
    .clk     (clk),
    .clear   (buf_clear),
    .wr_en   (buf_we),
    .wr_ptr  (ptr),
    .wr_data (buf_wdata),
    .rd_idx  (buf_rd_idx),
    .rd_word (buf_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FILL;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d      = state;
    in_ready     = 1'b0;
    digest_valid = 1'b0;
    core_cmd_w   = 1'b0;
    core_cmd_i   = 3'b000;
    buf_we       = 1'b0;
    buf_wdata    = in_data;
    unique case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          buf_we = 1'b1;
          if (at_end) begin
            state_d = S_START;
          end else if (in_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        buf_we = 1'b1;
        if (need80) begin
          buf_wdata = 8'h80;
        end else if (in_len_field) begin
          buf_wdata = 8'(len64 >> {~ptr[2:0], 3'b000});
        end else begin
          buf_wdata = 8'h00;
        end
        if (at_end) begin
          state_d = S_START;
        end
      end
      S_START: begin
        core_cmd_w = 1'b1;
        core_cmd_i = first_blk ? CMD_START : CMD_CONT;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (word_idx == 4'd15) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!busy) begin
          if (final_blk) begin
            state_d = S_RDCMD;
          end else if (pad_pending) begin
            state_d = S_PAD;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_RDCMD: begin
        core_cmd_w = 1'b1;
        core_cmd_i = CMD_READ;
        state_d    = S_READ;
      end
      S_READ: begin
        if (rd_capture && (rd_word_idx == 3'd7)) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      bitlen      <= '0;
      need80      <= 1'b0;
      no_len      <= 1'b0;
      final_blk   <= 1'b0;
      pad_pending <= 1'b0;
      first_blk   <= 1'b1;
      word_idx    <= '0;
      rd_cnt      <= '0;
      digest      <= '0;
      core_din    <= '0;
    end else begin
      unique case (state)
        S_FILL: begin
          if (in_valid) begin
            bitlen <= bitlen + LEN_W'(8);
            if (at_end) begin
              final_blk <= 1'b0;
              if (in_last) begin
                pad_pending <= 1'b1;
                need80      <= 1'b1;
              end
            end else begin
              ptr <= ptr + 6'd1;
              if (in_last) begin
                need80 <= 1'b1;
                no_len <= 1'b0;
              end
            end
          end
        end
        S_PAD: begin
          if (need80) begin
            need80 <= 1'b0;
            no_len <= (ptr >= 6'(LEN_OFS));
          end
          if (at_end) begin
            final_blk   <= block_has_len;
            pad_pending <= !block_has_len;
          end else begin
            ptr <= ptr + 6'd1;
          end
        end
        S_START: begin
          first_blk <= 1'b0;
          word_idx  <= '0;
          core_din  <= buf_word;
        end
        S_SEND: begin
          word_idx <= word_idx + 4'd1;
          if (word_idx != 4'd15) begin
            core_din <= buf_word;
          end else if (ZEROIZE) begin
            core_din <= '0;
          end
        end
        S_WAIT: begin
          if (!busy) begin
            ptr    <= '0;
            rd_cnt <= '0;
            if (!final_blk && pad_pending) begin
              pad_pending <= 1'b0;
              no_len      <= 1'b0;
            end
          end
        end
        S_READ: begin
          rd_cnt <= rd_cnt + RD_W'(1);
          if (rd_capture) begin
            digest[{~rd_word_idx, 5'b00000} +: 32] <= core_dout;
          end
        end
        S_OUT: begin
          if (digest_ready) begin
            bitlen    <= '0;
            first_blk <= 1'b1;
            if (ZEROIZE) begin
              digest <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
